// File: rtl/ac_motor_pkg.sv
// Shared state/direction types and default sizing for the AC motor direction
// sequencer and its ramp prescaler.
package ac_motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP      = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_DWELL     = 3'd4,
    ST_FAULTED   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    DIR_STOP = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_e;

  localparam int DEF_AMP_BITS    = 12;
  localparam int DEF_RAMP_STEP   = 16;
  localparam int DEF_RAMP_DIV    = 64;
  localparam int DEF_STOP_CYCLES = 1000;
  localparam int DEF_CNT_BITS    = 16;

endpackage

// File: rtl/ac_motor_tick_gen.sv
// Free-running prescaler: raises tick_o for one cycle out of every RAMP_DIV,
// independent of what the sequencer FSM is doing.
module ac_motor_tick_gen
  import ac_motor_pkg::*;
#(
  parameter int RAMP_DIV = DEF_RAMP_DIV,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(RAMP_DIV - 1);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/ac_motor_direction_sequencer.sv
// Supervisory sequencer for the AC motor bridge: ramps amplitude, never reverses
// under load, idles the bridge for a fixed dwell and latches shutdown on fault.
module ac_motor_direction_sequencer
  import ac_motor_pkg::*;
#(
  parameter int AMP_BITS    = DEF_AMP_BITS,
  parameter int RAMP_STEP   = DEF_RAMP_STEP,
  parameter int RAMP_DIV    = DEF_RAMP_DIV,
  parameter int STOP_CYCLES = DEF_STOP_CYCLES,
  parameter int CNT_BITS    = DEF_CNT_BITS
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_cw_i,
  input  logic                cmd_ccw_i,
  input  logic [AMP_BITS-1:0] cmd_amp_i,
  input  logic                fault_i,
  output logic                cw_o,
  output logic                ccw_o,
  output logic                enable_o,
  output logic [AMP_BITS-1:0] amp_o,
  output logic                busy_o,
  output logic [2:0]          state_o
);

  localparam logic [AMP_BITS-1:0] STEP       = AMP_BITS'(RAMP_STEP);
  localparam logic [CNT_BITS-1:0] DWELL_LOAD = CNT_BITS'(STOP_CYCLES - 1);

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  dir_e                req;
  logic [AMP_BITS-1:0] amp_q, amp_d;
  logic [CNT_BITS-1:0] dwell_q, dwell_d;
  logic [AMP_BITS-1:0] gap, upStep, downStep, ampToward, ampDown;
  logic                tick;

  ac_motor_tick_gen #(
    .RAMP_DIV (RAMP_DIV),
    .CNT_BITS (CNT_BITS)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (tick)
  );

  // Contradictory or zero-amplitude commands both mean "stop".
  always_comb begin
    req = DIR_STOP;
    if (cmd_amp_i != '0) begin
      if (cmd_cw_i && !cmd_ccw_i) begin
        req = DIR_CW;
      end else if (cmd_ccw_i && !cmd_cw_i) begin
        req = DIR_CCW;
      end
    end
  end

  // Step sizes are clamped to the remaining distance so the ramp never
  // overshoots the target or wraps through zero.
  always_comb begin
    gap       = (cmd_amp_i > amp_q) ? cmd_amp_i - amp_q : amp_q - cmd_amp_i;
    upStep    = (gap < STEP) ? gap : STEP;
    ampToward = (cmd_amp_i > amp_q) ? amp_q + upStep : amp_q - upStep;
    downStep  = (amp_q < STEP) ? amp_q : STEP;
    ampDown   = amp_q - downStep;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_STOP;
      amp_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      amp_q   <= amp_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    amp_d   = amp_q;
    dwell_d = dwell_q;
    if (fault_i) begin
      state_d = ST_FAULTED;
      amp_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          amp_d = '0;
          if (req != DIR_STOP) begin
            dir_d   = req;
            state_d = ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (req != dir_q) begin
            state_d = ST_RAMP_DOWN;
          end else if (amp_q == cmd_amp_i) begin
            state_d = ST_RUN;
          end else if (tick) begin
            amp_d = ampToward;
          end
        end
        ST_RUN: begin
          if (req != dir_q) begin
            state_d = ST_RAMP_DOWN;
          end else if (amp_q != cmd_amp_i) begin
            state_d = ST_RAMP;
          end
        end
        // Requests are ignored until the bridge has been fully unloaded.
        ST_RAMP_DOWN: begin
          if (amp_q == '0) begin
            state_d = ST_DWELL;
            dwell_d = DWELL_LOAD;
          end else if (tick) begin
            amp_d = ampDown;
          end
        end
        ST_DWELL: begin
          if (dwell_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            dwell_d = dwell_q - CNT_BITS'(1);
          end
        end
        ST_FAULTED: begin
          amp_d = '0;
          if (req == DIR_STOP) begin
            state_d = ST_DWELL;
            dwell_d = DWELL_LOAD;
          end
        end
        default: begin
          state_d = ST_IDLE;
          amp_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cw_o     = 1'b0;
    ccw_o    = 1'b0;
    enable_o = 1'b0;
    case (state_q)
      ST_RAMP, ST_RUN, ST_RAMP_DOWN: begin
        enable_o = 1'b1;
        cw_o     = (dir_q == DIR_CW);
        ccw_o    = (dir_q == DIR_CCW);
      end
      default: begin
        enable_o = 1'b0;
      end
    endcase
    busy_o = (state_q == ST_RAMP) || (state_q == ST_RAMP_DOWN) || (state_q == ST_DWELL);
  end

  assign amp_o   = amp_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ac_motor_direction_sequencer.sv
// Directed and randomised bench for the AC motor direction sequencer, compared
// every cycle against a phase-level behavioural model of the controller.
module tb_ac_motor_direction_sequencer;

  localparam int AMP_BITS    = 12;
  localparam int RAMP_STEP   = 16;
  localparam int RAMP_DIV    = 4;
  localparam int STOP_CYCLES = 8;
  localparam int CNT_BITS    = 16;

  localparam int S_IDLE      = 0;
  localparam int S_RAMP      = 1;
  localparam int S_RUN       = 2;
  localparam int S_RAMP_DOWN = 3;
  localparam int S_DWELL     = 4;
  localparam int S_FAULTED   = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmdCw;
  logic                cmdCcw;
  logic [AMP_BITS-1:0] cmdAmp;
  logic                fault;
  logic                cw;
  logic                ccw;
  logic                enable;
  logic [AMP_BITS-1:0] amp;
  logic                busy;
  logic [2:0]          state;

  int checks = 0;
  int errors = 0;

  int mPhase;
  int mAmp;
  int mDir;
  int mDwellLeft;
  int mPresc;

  int   ampTrace[$];
  int   lastAmp;
  int   dwellSeen;
  logic prevCw = 1'b0;
  logic prevCcw = 1'b0;

  ac_motor_direction_sequencer #(
    .AMP_BITS    (AMP_BITS),
    .RAMP_STEP   (RAMP_STEP),
    .RAMP_DIV    (RAMP_DIV),
    .STOP_CYCLES (STOP_CYCLES),
    .CNT_BITS    (CNT_BITS)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .cmd_cw_i  (cmdCw),
    .cmd_ccw_i (cmdCcw),
    .cmd_amp_i (cmdAmp),
    .fault_i   (fault),
    .cw_o      (cw),
    .ccw_o     (ccw),
    .enable_o  (enable),
    .amp_o     (amp),
    .busy_o    (busy),
    .state_o   (state)
  );

  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic cc,
                               input logic [AMP_BITS-1:0] a, input logic f);
    reset  = r;
    cmdCw  = c;
    cmdCcw = cc;
    cmdAmp = a;
    fault  = f;
  endtask

  // Reference behaviour: phase, amplitude and remaining dwell as plain integers.
  task automatic modelStep();
    int  req;
    int  delta;
    bit  tick;
    int  target;
    if (reset) begin
      mPhase = S_IDLE; mAmp = 0; mDir = 0; mDwellLeft = 0; mPresc = 0;
      return;
    end
    tick   = (mPresc == RAMP_DIV - 1);
    mPresc = (mPresc + 1) % RAMP_DIV;
    target = int'(cmdAmp);
    req = 0;
    if (target != 0 && cmdCw && !cmdCcw) req = 1;
    else if (target != 0 && cmdCcw && !cmdCw) req = -1;
    if (fault) begin
      mPhase = S_FAULTED;
      mAmp   = 0;
      return;
    end
    case (mPhase)
      S_IDLE: if (req != 0) begin mDir = req; mPhase = S_RAMP; end
      S_RAMP: begin
        if (req != mDir) mPhase = S_RAMP_DOWN;
        else if (mAmp == target) mPhase = S_RUN;
        else if (tick) begin
          delta = target - mAmp;
          if (delta > RAMP_STEP) delta = RAMP_STEP;
          if (delta < -RAMP_STEP) delta = -RAMP_STEP;
          mAmp += delta;
        end
      end
      S_RUN: begin
        if (req != mDir) mPhase = S_RAMP_DOWN;
        else if (mAmp != target) mPhase = S_RAMP;
      end
      S_RAMP_DOWN: begin
        if (mAmp == 0) begin mPhase = S_DWELL; mDwellLeft = STOP_CYCLES; end
        else if (tick) mAmp -= (mAmp < RAMP_STEP) ? mAmp : RAMP_STEP;
      end
      S_DWELL: begin
        mDwellLeft--;
        if (mDwellLeft == 0) mPhase = S_IDLE;
      end
      S_FAULTED: if (req == 0) begin mPhase = S_DWELL; mDwellLeft = STOP_CYCLES; end
      default: mPhase = S_IDLE;
    endcase
  endtask

  task automatic checkOutput();
    bit driving;
    driving = (mPhase == S_RAMP) || (mPhase == S_RUN) || (mPhase == S_RAMP_DOWN);
    checkOne("state", 32'(state), 32'(mPhase));
    checkOne("amp", 32'(amp), 32'(mAmp));
    checkOne("enable", 32'(enable), 32'(driving));
    checkOne("cw", 32'(cw), 32'(driving && mDir == 1));
    checkOne("ccw", 32'(ccw), 32'(driving && mDir == -1));
    checkOne("busy", 32'(busy),
             32'((mPhase == S_RAMP) || (mPhase == S_RAMP_DOWN) || (mPhase == S_DWELL)));
    checkOne("cw_ccw_exclusive", 32'(cw & ccw), 32'(0));
    checkOne("no_direct_reversal", 32'((prevCw & ccw) | (prevCcw & cw)), 32'(0));
    prevCw  = cw;
    prevCcw = ccw;
    if (int'(amp) != lastAmp) begin
      ampTrace.push_back(int'(amp));
      lastAmp = int'(amp);
    end
    if (int'(state) == S_DWELL && !enable) dwellSeen++;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic clearTrace();
    ampTrace.delete();
    lastAmp   = int'(amp);
    dwellSeen = 0;
  endtask

  task automatic runUntilState(input int target, input int budget);
    int n;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (int'(state) != target && n < budget);
    checkOne("reach_state", 32'(state), 32'(target));
  endtask

  task automatic checkTrace(input string tag, input int n, input int e0, input int e1,
                            input int e2, input int e3);
    int expv[4];
    expv = '{e0, e1, e2, e3};
    checkOne({tag, "_len"}, 32'(ampTrace.size()), 32'(n));
    for (int i = 0; i < n && i < ampTrace.size(); i++) begin
      checkOne($sformatf("%s_%0d", tag, i), 32'(ampTrace[i]), 32'(expv[i]));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit                  rst, cwBit, ccwBit, fBit;
    logic [AMP_BITS-1:0] aVal;
    int                  r;

    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    stepCycle();
    stepCycle();
    checkOne("reset_state", 32'(state), 32'(S_IDLE));
    checkOne("reset_amp", 32'(amp), 32'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (20) stepCycle();
    checkOne("idle_after_20", 32'(state), 32'(S_IDLE));

    $display("[TB] CW ramp to 64");
    clearTrace();
    applyStimulus(1'b0, 1'b1, 1'b0, AMP_BITS'(64), 1'b0);
    stepCycle();
    checkOne("cw_start_cw", 32'(cw), 32'(1));
    checkOne("cw_start_enable", 32'(enable), 32'(1));
    runUntilState(S_RUN, 40);
    checkTrace("ramp_cw64", 4, 16, 32, 48, 64);

    $display("[TB] reverse to CCW");
    clearTrace();
    applyStimulus(1'b0, 1'b0, 1'b1, AMP_BITS'(64), 1'b0);
    runUntilState(S_DWELL, 40);
    checkTrace("ramp_down", 4, 48, 32, 16, 0);
    runUntilState(S_IDLE, 20);
    checkOne("dwell_len", 32'(dwellSeen), 32'(STOP_CYCLES));
    clearTrace();
    stepCycle();
    checkOne("ccw_start_ccw", 32'(ccw), 32'(1));
    checkOne("ccw_start_cw", 32'(cw), 32'(0));
    runUntilState(S_RUN, 40);
    checkTrace("ramp_ccw64", 4, 16, 32, 48, 64);

    $display("[TB] partial step ramps");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    runUntilState(S_IDLE, 60);
    clearTrace();
    applyStimulus(1'b0, 1'b1, 1'b0, AMP_BITS'(40), 1'b0);
    runUntilState(S_RUN, 40);
    checkTrace("ramp_40", 3, 16, 32, 40, 0);
    clearTrace();
    applyStimulus(1'b0, 1'b1, 1'b0, AMP_BITS'(8), 1'b0);
    runUntilState(S_RUN, 40);
    checkTrace("ramp_to_8", 2, 24, 8, 0, 0);

    $display("[TB] fault handling");
    applyStimulus(1'b0, 1'b1, 1'b0, AMP_BITS'(8), 1'b1);
    stepCycle();
    checkOne("fault_amp", 32'(amp), 32'(0));
    checkOne("fault_enable", 32'(enable), 32'(0));
    checkOne("fault_state", 32'(state), 32'(S_FAULTED));
    applyStimulus(1'b0, 1'b1, 1'b0, AMP_BITS'(8), 1'b0);
    repeat (5) stepCycle();
    checkOne("fault_held", 32'(state), 32'(S_FAULTED));
    clearTrace();
    applyStimulus(1'b0, 1'b0, 1'b0, AMP_BITS'(8), 1'b0);
    runUntilState(S_IDLE, 20);
    checkOne("fault_dwell_len", 32'(dwellSeen), 32'(STOP_CYCLES));

    $display("[TB] conflicting command and reset mid-ramp");
    applyStimulus(1'b0, 1'b1, 1'b1, AMP_BITS'(100), 1'b0);
    repeat (10) stepCycle();
    checkOne("conflict_idle", 32'(state), 32'(S_IDLE));
    applyStimulus(1'b0, 1'b1, 1'b0, AMP_BITS'(200), 1'b0);
    runUntilState(S_RAMP, 3);
    repeat (6) stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, AMP_BITS'(200), 1'b0);
    stepCycle();
    checkOne("midramp_reset_state", 32'(state), 32'(S_IDLE));
    checkOne("midramp_reset_amp", 32'(amp), 32'(0));
    checkOne("midramp_reset_cw", 32'(cw), 32'(0));
    checkOne("midramp_reset_enable", 32'(enable), 32'(0));
    checkOne("midramp_reset_busy", 32'(busy), 32'(0));

    $display("[TB] randomised command sequence");
    rst = 1'b0; cwBit = 1'b0; ccwBit = 1'b0; fBit = 1'b0; aVal = '0;
    for (int seg = 0; seg < 250; seg++) begin
      r = int'($urandom_range(0, 99));
      if (r >= 30 || seg == 0) begin
        rst    = (r < 3);
        fBit   = (r >= 3 && r < 10);
        cwBit  = ($urandom_range(0, 3) != 0);
        ccwBit = ($urandom_range(0, 3) == 0);
        aVal   = ($urandom_range(0, 3) == 0) ? '0 : AMP_BITS'($urandom_range(1, 200));
      end else begin
        rst  = 1'b0;
        fBit = 1'b0;
      end
      applyStimulus(rst, cwBit, ccwBit, aVal, fBit);
      repeat ($urandom_range(1, 40)) stepCycle();
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (5) stepCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
